// File: rtl/cc_demux_router.sv
// -----------------------------------------------------------------------------
// cc_demux_router
//
// Registered 1-to-8 demultiplexer. One producer stream with a valid/ready
// handshake is steered to one of eight consumer channels. Each channel owns a
// one-entry output register with its own valid/ready handshake, so a stalled
// consumer only blocks words addressed to that consumer.
//
// Ports
//   CC_DEMUX_CLOCK_50           in   clock, rising edge
//   CC_DEMUX_RESET_InHigh       in   asynchronous active-high reset
//   CC_DEMUX_data_InBUS         in   producer data
//   CC_DEMUX_selection_InBUS    in   destination channel, qualified by valid_In
//   CC_DEMUX_valid_In           in   producer presents a word
//   CC_DEMUX_ready_Out          out  word accepted this cycle (combinational)
//   CC_DEMUX_dataN_OutBUS       out  channel N data, registered (N = 0..7)
//   CC_DEMUX_validN_Out         out  channel N holds a word, registered
//   CC_DEMUX_readyN_In          in   channel N consumer takes the word
//   CC_DEMUX_drop_count_OutBUS  out  saturating count of discarded words
//                                    (present only with the macro below)
//
// Build option
//   CC_DEMUX_DROP_COUNT_EN  undefined: selects >= 8 are routed to channel 0.
//                           defined:   selects >= 8 are accepted and discarded,
//                                      and a saturating 8-bit counter
//                                      records each discard.
// -----------------------------------------------------------------------------
module cc_demux_router #(
  parameter int DATAWIDTH_MUX_SELECTION = 4,
  parameter int DATAWIDTH_BUS           = 8
) (
  input  logic                               CC_DEMUX_CLOCK_50,
  input  logic                               CC_DEMUX_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data_InBUS,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0] CC_DEMUX_selection_InBUS,
  input  logic                               CC_DEMUX_valid_In,
  output logic                               CC_DEMUX_ready_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data0_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data1_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data2_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data3_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data4_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data5_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data6_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data7_OutBUS,
  output logic                               CC_DEMUX_valid0_Out,
  output logic                               CC_DEMUX_valid1_Out,
  output logic                               CC_DEMUX_valid2_Out,
  output logic                               CC_DEMUX_valid3_Out,
  output logic                               CC_DEMUX_valid4_Out,
  output logic                               CC_DEMUX_valid5_Out,
  output logic                               CC_DEMUX_valid6_Out,
  output logic                               CC_DEMUX_valid7_Out,
  input  logic                               CC_DEMUX_ready0_In,
  input  logic                               CC_DEMUX_ready1_In,
  input  logic                               CC_DEMUX_ready2_In,
  input  logic                               CC_DEMUX_ready3_In,
  input  logic                               CC_DEMUX_ready4_In,
  input  logic                               CC_DEMUX_ready5_In,
  input  logic                               CC_DEMUX_ready6_In,
  input  logic                               CC_DEMUX_ready7_In
`ifdef CC_DEMUX_DROP_COUNT_EN
  ,
  output logic [7:0]                         CC_DEMUX_drop_count_OutBUS
`endif
);

  localparam int NCH = 8;
  // Channel count expressed in the select width, so the range test below is
  // a same-width comparison.
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0] NCH_SEL = DATAWIDTH_MUX_SELECTION'(NCH);

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH_BUS-1:0] r_data [NCH];
  logic [NCH-1:0]           r_valid;

  logic [NCH-1:0]           w_ready_ch;   // consumer ready, gathered into a vector
  logic [NCH-1:0]           w_free;       // channel can take a word this cycle
  logic [NCH-1:0]           w_load;       // one-hot load strobe (at most one bit)
  logic                     w_in_range;   // select addresses a real channel
  logic [2:0]               w_ch;         // decoded destination channel
  logic                     w_accept;     // input handshake completes this cycle

  assign w_ready_ch = {CC_DEMUX_ready7_In, CC_DEMUX_ready6_In,
                       CC_DEMUX_ready5_In, CC_DEMUX_ready4_In,
                       CC_DEMUX_ready3_In, CC_DEMUX_ready2_In,
                       CC_DEMUX_ready1_In, CC_DEMUX_ready0_In};

  assign w_in_range = (CC_DEMUX_selection_InBUS < NCH_SEL);

  // A full channel is still free when its consumer drains it on this edge;
  // that is what gives back-to-back throughput on a single channel.
  assign w_free = ~r_valid | w_ready_ch;

  // ---------------------------------------------------------------------------
  // Destination decode and input handshake
  // ---------------------------------------------------------------------------
`ifdef CC_DEMUX_DROP_COUNT_EN
  logic       w_drop;
  logic [7:0] r_drop_count;

  // Out-of-range selects have nowhere to go, so they are always accepted and
  // thrown away; w_ch is then irrelevant because no load strobe fires.
  assign w_ch               = CC_DEMUX_selection_InBUS[2:0];
  assign CC_DEMUX_ready_Out = w_in_range ? w_free[w_ch] : 1'b1;
  assign w_accept           = CC_DEMUX_valid_In & CC_DEMUX_ready_Out;
  assign w_drop             = w_accept & ~w_in_range;

  always_comb begin
    w_load = '0;
    if (w_accept && w_in_range) begin
      w_load[w_ch] = 1'b1;
    end
  end

  // Saturating discard counter; only reset clears it.
  always_ff @(posedge CC_DEMUX_CLOCK_50 or posedge CC_DEMUX_RESET_InHigh) begin
    if (CC_DEMUX_RESET_InHigh) begin
      r_drop_count <= 8'h00;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'h01;
    end
  end

  assign CC_DEMUX_drop_count_OutBUS = r_drop_count;
`else
  // Out-of-range selects fall back to channel 0, like the matching 8:1 mux.
  assign w_ch               = w_in_range ? CC_DEMUX_selection_InBUS[2:0] : 3'd0;
  assign CC_DEMUX_ready_Out = w_free[w_ch];
  assign w_accept           = CC_DEMUX_valid_In & CC_DEMUX_ready_Out;

  always_comb begin
    w_load = '0;
    if (w_accept) begin
      w_load[w_ch] = 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Per-channel one-entry output registers
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      always_ff @(posedge CC_DEMUX_CLOCK_50 or posedge CC_DEMUX_RESET_InHigh) begin
        if (CC_DEMUX_RESET_InHigh) begin
          r_valid[gi] <= 1'b0;
          r_data[gi]  <= '0;
        end else if (w_load[gi]) begin
          // Load wins over drain: a simultaneous drain-and-load keeps valid
          // high with the new word, so there is no bubble.
          r_valid[gi] <= 1'b1;
          r_data[gi]  <= CC_DEMUX_data_InBUS;
        end else if (r_valid[gi] && w_ready_ch[gi]) begin
          // Plain drain: data is left holding its last value.
          r_valid[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output fan-out
  // ---------------------------------------------------------------------------
  assign CC_DEMUX_data0_OutBUS = r_data[0];
  assign CC_DEMUX_data1_OutBUS = r_data[1];
  assign CC_DEMUX_data2_OutBUS = r_data[2];
  assign CC_DEMUX_data3_OutBUS = r_data[3];
  assign CC_DEMUX_data4_OutBUS = r_data[4];
  assign CC_DEMUX_data5_OutBUS = r_data[5];
  assign CC_DEMUX_data6_OutBUS = r_data[6];
  assign CC_DEMUX_data7_OutBUS = r_data[7];

  assign CC_DEMUX_valid0_Out = r_valid[0];
  assign CC_DEMUX_valid1_Out = r_valid[1];
  assign CC_DEMUX_valid2_Out = r_valid[2];
  assign CC_DEMUX_valid3_Out = r_valid[3];
  assign CC_DEMUX_valid4_Out = r_valid[4];
  assign CC_DEMUX_valid5_Out = r_valid[5];
  assign CC_DEMUX_valid6_Out = r_valid[6];
  assign CC_DEMUX_valid7_Out = r_valid[7];

endmodule

// File: tb/tb_cc_demux_router.sv
// -----------------------------------------------------------------------------
// tb_cc_demux_router
//
// Directed scenarios followed by a randomized run compared every cycle
// against a behavioural model of eight one-entry channel buffers.
// -----------------------------------------------------------------------------
module tb_cc_demux_router;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [3:0] sel;
  logic       vin;
  logic       rdy_out;
  logic [7:0] d_out [8];
  logic [7:0] v_out;
  logic [7:0] rdy_in;
`ifdef CC_DEMUX_DROP_COUNT_EN
  logic [7:0] drop_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  cc_demux_router #(
    .DATAWIDTH_MUX_SELECTION(4),
    .DATAWIDTH_BUS(8)
  ) dut (
    .CC_DEMUX_CLOCK_50        (clk),
    .CC_DEMUX_RESET_InHigh    (rst),
    .CC_DEMUX_data_InBUS      (din),
    .CC_DEMUX_selection_InBUS (sel),
    .CC_DEMUX_valid_In        (vin),
    .CC_DEMUX_ready_Out       (rdy_out),
    .CC_DEMUX_data0_OutBUS    (d_out[0]),
    .CC_DEMUX_data1_OutBUS    (d_out[1]),
    .CC_DEMUX_data2_OutBUS    (d_out[2]),
    .CC_DEMUX_data3_OutBUS    (d_out[3]),
    .CC_DEMUX_data4_OutBUS    (d_out[4]),
    .CC_DEMUX_data5_OutBUS    (d_out[5]),
    .CC_DEMUX_data6_OutBUS    (d_out[6]),
    .CC_DEMUX_data7_OutBUS    (d_out[7]),
    .CC_DEMUX_valid0_Out      (v_out[0]),
    .CC_DEMUX_valid1_Out      (v_out[1]),
    .CC_DEMUX_valid2_Out      (v_out[2]),
    .CC_DEMUX_valid3_Out      (v_out[3]),
    .CC_DEMUX_valid4_Out      (v_out[4]),
    .CC_DEMUX_valid5_Out      (v_out[5]),
    .CC_DEMUX_valid6_Out      (v_out[6]),
    .CC_DEMUX_valid7_Out      (v_out[7]),
    .CC_DEMUX_ready0_In       (rdy_in[0]),
    .CC_DEMUX_ready1_In       (rdy_in[1]),
    .CC_DEMUX_ready2_In       (rdy_in[2]),
    .CC_DEMUX_ready3_In       (rdy_in[3]),
    .CC_DEMUX_ready4_In       (rdy_in[4]),
    .CC_DEMUX_ready5_In       (rdy_in[5]),
    .CC_DEMUX_ready6_In       (rdy_in[6]),
    .CC_DEMUX_ready7_In       (rdy_in[7])
`ifdef CC_DEMUX_DROP_COUNT_EN
    ,
    .CC_DEMUX_drop_count_OutBUS(drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_data();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = d_out[i];
    return v;
  endfunction

  // Apply inputs just after the falling edge.
  task automatic drive(input logic v, input logic [3:0] s, input logic [7:0] d, input logic [7:0] r);
    @(negedge clk);
    vin    = v;
    sel    = s;
    din    = d;
    rdy_in = r;
    #1;
  endtask

  // Advance through the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference: eight single-word buffers plus a discard counter.
  // ---------------------------------------------------------------------------
  logic [7:0] m_data [8];
  logic [7:0] m_valid;
  int         m_drops;

  function automatic bit sel_fits(input logic [3:0] s);
    return int'(s) < 8;
  endfunction

  // Which buffer a select targets when it is not discarded.
  function automatic int target(input logic [3:0] s);
    return sel_fits(s) ? int'(s) : 0;
  endfunction

  function automatic bit model_ready(input logic [3:0] s, input logic [7:0] r);
`ifdef CC_DEMUX_DROP_COUNT_EN
    if (!sel_fits(s)) return 1'b1;
`endif
    return !m_valid[target(s)] || r[target(s)];
  endfunction

  function automatic logic [63:0] model_data();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_data[i];
    return v;
  endfunction

  initial begin
    int         k;
    int         chs [7];
    bit         hold;
    bit         exp_rdy;
    logic [3:0] s;
    logic [7:0] d;

    rst = 1'b1; vin = 1'b0; sel = 4'h0; din = 8'h00; rdy_in = 8'h00;
    #2;
    check_eq("reset_valid", {56'h0, v_out}, 64'h0);
    check_eq("reset_data", all_data(), 64'h0);
`ifdef CC_DEMUX_DROP_COUNT_EN
    check_eq("reset_drops", {56'h0, drop_cnt}, 64'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // ---- A5 to channel 3 ----------------------------------------------------
    drive(1'b1, 4'd3, 8'hA5, 8'h08);
    check_eq("ch3_ready", {63'h0, rdy_out}, 64'h1);
    step();
    check_eq("ch3_valid", {56'h0, v_out}, 64'h08);
    check_eq("ch3_data", {56'h0, d_out[3]}, 64'hA5);
    drive(1'b0, 4'd0, 8'h00, 8'h08);
    step();
    check_eq("ch3_drained", {56'h0, v_out}, 64'h0);
    check_eq("ch3_data_hold", {56'h0, d_out[3]}, 64'hA5);

    // ---- backpressure on channel 5 -------------------------------------------
    drive(1'b1, 4'd5, 8'h11, 8'h00);
    step();
    check_eq("ch5_load", {56'h0, d_out[5]}, 64'h11);
    drive(1'b1, 4'd5, 8'h22, 8'h00);
    check_eq("ch5_stall_ready", {63'h0, rdy_out}, 64'h0);
    step();
    check_eq("ch5_stall_data", {56'h0, d_out[5]}, 64'h11);
    check_eq("ch5_stall_valid", {56'h0, v_out}, 64'h20);
    drive(1'b1, 4'd5, 8'h22, 8'h20);
    check_eq("ch5_release_ready", {63'h0, rdy_out}, 64'h1);
    step();
    check_eq("ch5_swap_data", {56'h0, d_out[5]}, 64'h22);
    check_eq("ch5_swap_valid", {56'h0, v_out}, 64'h20);
    drive(1'b0, 4'd0, 8'h00, 8'h20);
    step();

    // ---- channel 2 stalled, others keep flowing ------------------------------
    drive(1'b1, 4'd2, 8'h77, 8'h00);
    step();
    chs = '{0, 1, 3, 4, 5, 6, 7};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'(chs[i]), 8'(i + 1), 8'h00);
      check_eq($sformatf("indep_ready_ch%0d", chs[i]), {63'h0, rdy_out}, 64'h1);
      step();
      check_eq($sformatf("indep_data_ch%0d", chs[i]), {56'h0, d_out[chs[i]]}, 64'(i + 1));
    end
    check_eq("indep_valid_all", {56'h0, v_out}, 64'hFF);
    check_eq("indep_ch2_kept", {56'h0, d_out[2]}, 64'h77);
    drive(1'b0, 4'd0, 8'h00, 8'hFF);
    step();
    check_eq("drain_all", {56'h0, v_out}, 64'h0);

`ifdef CC_DEMUX_DROP_COUNT_EN
    // ---- out-of-range selects are discarded and counted ----------------------
    k = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'hF, 8'(i), 8'h00);
      if (rdy_out !== 1'b1) k++;
      step();
      if (v_out !== 8'h00) k++;
    end
    check_eq("drop_ready_or_valid_errors", 64'(k), 64'h0);
    check_eq("drop_count_sat", {56'h0, drop_cnt}, 64'hFF);
`else
    // ---- out-of-range selects fall back to channel 0 -------------------------
    drive(1'b1, 4'hC, 8'h3C, 8'h00);
    check_eq("oor_ready", {63'h0, rdy_out}, 64'h1);
    step();
    check_eq("oor_valid", {56'h0, v_out}, 64'h01);
    check_eq("oor_data", {56'h0, d_out[0]}, 64'h3C);
`endif

    // ---- asynchronous reset with words held ----------------------------------
    drive(1'b1, 4'd6, 8'h5A, 8'h00);
    step();
    check_eq("pre_reset_valid6", {63'h0, v_out[6]}, 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_reset_valid", {56'h0, v_out}, 64'h0);
    check_eq("async_reset_data", all_data(), 64'h0);
`ifdef CC_DEMUX_DROP_COUNT_EN
    check_eq("async_reset_drops", {56'h0, drop_cnt}, 64'h0);
`endif
    @(negedge clk);
    vin = 1'b0;
    rst = 1'b0;

    // ---- randomized run against the buffer model -----------------------------
    for (int i = 0; i < 8; i++) m_data[i] = 8'h00;
    m_valid = 8'h00;
    m_drops = 0;
    hold    = 1'b0;
    s       = 4'h0;
    d       = 8'h00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      // A stalled word must be re-presented unchanged.
      if (!hold) begin
        vin = ($urandom_range(0, 3) != 0);
        s   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        d   = 8'($urandom);
      end
      sel    = s;
      din    = d;
      rdy_in = 8'($urandom) | 8'($urandom);
      #1;
      exp_rdy = model_ready(s, rdy_in);
      check_eq("rand_ready", {63'h0, rdy_out}, {63'h0, exp_rdy});

      @(posedge clk);
      // Consumers take whatever they were offered, then the new word lands.
      m_valid = m_valid & ~rdy_in;
      if (vin && exp_rdy) begin
`ifdef CC_DEMUX_DROP_COUNT_EN
        if (!sel_fits(s)) begin
          if (m_drops < 255) m_drops++;
        end else begin
          m_valid[target(s)] = 1'b1;
          m_data[target(s)]  = d;
        end
`else
        m_valid[target(s)] = 1'b1;
        m_data[target(s)]  = d;
`endif
      end
      hold = vin && !exp_rdy;
      #1;
      check_eq("rand_valid", {56'h0, v_out}, {56'h0, m_valid});
      check_eq("rand_data", all_data(), model_data());
`ifdef CC_DEMUX_DROP_COUNT_EN
      check_eq("rand_drops", {56'h0, drop_cnt}, 64'(m_drops));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
